// File: rtl/ahb_muldiv_pkg.sv
// Shared definitions for the AHB multiply/divide accelerator: register map,
// CTRL/STATUS bit positions, sequencer states and a small arithmetic helper.
package ahb_muldiv_pkg;

    localparam logic [7:0] OFF_OPA    = 8'h00;
    localparam logic [7:0] OFF_OPB    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_RES_LO = 8'h10;
    localparam logic [7:0] OFF_RES_HI = 8'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_OP     = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DBZ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        if (neg) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/ahb_muldiv_accel_if.sv
// AHB-Lite signal bundle between a bus master and the accelerator slave.
interface ahb_muldiv_accel_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_muldiv_core.sv
// Sequential multiply/divide engine: sign-magnitude prep, DATA_W-step
// shift-add / restoring divide, then sign fix-up into 32-bit results.
module ahb_muldiv_core
    import ahb_muldiv_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              is_signed,
    input  logic              op,
    output logic              busy,
    output logic              done_p,
    output logic              dbz_p,
    output logic [31:0]       res_lo,
    output logic [31:0]       res_hi
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state_r;
    logic [DATA_W-1:0] a_r, b_r, b_mag_r, quo_r, rem_r;
    logic              sgn_r, op_r, dbz_r, neg_q_r, neg_r_r, busy_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       res_lo_r, res_hi_r;

    logic [DATA_W-1:0] a_mag_s, b_mag_s, div_rem_s, q_w_s, r_w_s;
    logic [DATA_W:0]   mul_sum_s, div_shift_s;
    logic              div_ok_s, b_zero_s;
    logic [31:0]       prod_s, res_lo_s, res_hi_s;

    function automatic logic [31:0] extend(input logic [DATA_W-1:0] v, input logic s);
        if (s) begin
            return {{(32-DATA_W){v[DATA_W-1]}}, v};
        end else begin
            return 32'(v);
        end
    endfunction

    // Magnitudes, one iteration step for each operation, and the final results
    always_comb begin
        a_mag_s     = (sgn_r && a_r[DATA_W-1]) ? -a_r : a_r;
        b_mag_s     = (sgn_r && b_r[DATA_W-1]) ? -b_r : b_r;
        b_zero_s    = (b_r == {DATA_W{1'b0}});
        mul_sum_s   = {1'b0, rem_r} + (quo_r[0] ? {1'b0, b_mag_r} : {(DATA_W+1){1'b0}});
        div_shift_s = {rem_r, quo_r[DATA_W-1]};
        div_ok_s    = (div_shift_s >= {1'b0, b_mag_r});
        div_rem_s   = div_ok_s ? DATA_W'(div_shift_s - {1'b0, b_mag_r})
                               : div_shift_s[DATA_W-1:0];
        // Quotient is negated in DATA_W bits so MIN / -1 wraps back to MIN
        q_w_s       = neg_q_r ? -quo_r : quo_r;
        r_w_s       = neg_r_r ? -rem_r : rem_r;
        prod_s      = 32'({rem_r, quo_r});
        if (dbz_r) begin
            res_lo_s = 32'({DATA_W{1'b1}});
            res_hi_s = extend(a_r, sgn_r);
        end else if (op_r) begin
            res_lo_s = extend(q_w_s, sgn_r);
            res_hi_s = extend(r_w_s, sgn_r);
        end else begin
            res_lo_s = cond_neg(prod_s, neg_q_r);
            res_hi_s = 32'h0000_0000;
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= {DATA_W{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            b_mag_r  <= {DATA_W{1'b0}};
            quo_r    <= {DATA_W{1'b0}};
            rem_r    <= {DATA_W{1'b0}};
            sgn_r    <= 1'b0;
            op_r     <= 1'b0;
            dbz_r    <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            busy_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            res_lo_r <= 32'h0000_0000;
            res_hi_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sgn_r   <= is_signed;
                        op_r    <= op;
                        busy_r  <= 1'b1;
                        state_r <= PREP;
                    end
                end
                PREP: begin
                    neg_q_r <= sgn_r & (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
                    neg_r_r <= sgn_r & a_r[DATA_W-1];
                    b_mag_r <= b_mag_s;
                    quo_r   <= a_mag_s;
                    rem_r   <= {DATA_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    dbz_r   <= op_r & b_zero_s;
                    state_r <= (op_r && b_zero_s) ? FIX : RUN;
                end
                RUN: begin
                    if (op_r) begin
                        rem_r <= div_rem_s;
                        quo_r <= {quo_r[DATA_W-2:0], div_ok_s};
                    end else begin
                        rem_r <= mul_sum_s[DATA_W:1];
                        quo_r <= {mul_sum_s[0], quo_r[DATA_W-1:1]};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    res_lo_r <= res_lo_s;
                    res_hi_r <= res_hi_s;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done_p = (state_r == FIX);
    assign dbz_p  = (state_r == FIX) & dbz_r;
    assign res_lo = res_lo_r;
    assign res_hi = res_hi_r;

endmodule

// File: rtl/ahb_muldiv_accel.sv
// AHB-Lite slave front end and register file for the multiply/divide engine.
// Zero wait state; read data is decoded from the registered address phase.
module ahb_muldiv_accel
    import ahb_muldiv_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [31:0] RST_RDATA = 32'hFFFF_FFFF
) (
    input  logic              AHB_HCLK,
    input  logic              AHB_HRESET,
    ahb_muldiv_accel_if.slave bus,
    output logic              IRQ
);

    logic [7:0]        addr_r;
    logic              sel_r, trans_r, write_r;
    logic [DATA_W-1:0] opa_r, opb_r, opa_n, opb_n;
    logic              sgn_r, op_r, irq_en_r, done_r, dbz_r, irq_r;
    logic              sgn_n, op_n, irq_en_n, done_n, dbz_n, irq_n;

    logic              wr_en_s, rd_en_s, start_s, busy_s, done_p_s, dbz_p_s;
    logic [31:0]       res_lo_s, res_hi_s, rdata_s;
    logic              unused_s;

    assign wr_en_s  = sel_r & trans_r & write_r;
    assign rd_en_s  = sel_r & trans_r & ~write_r;
    assign start_s  = wr_en_s & (addr_r == OFF_CTRL) & bus.hwdata[CTRL_START] & ~busy_s;
    assign unused_s = ^{bus.hsize, bus.haddr[31:8], bus.htrans[0], bus.hwdata};

    ahb_muldiv_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk       (AHB_HCLK),
        .rst       (AHB_HRESET),
        .start     (start_s),
        .a         (opa_r),
        .b         (opb_r),
        .is_signed (bus.hwdata[CTRL_SIGNED]),
        .op        (bus.hwdata[CTRL_OP]),
        .busy      (busy_s),
        .done_p    (done_p_s),
        .dbz_p     (dbz_p_s),
        .res_lo    (res_lo_s),
        .res_hi    (res_hi_s)
    );

    // Next-state of the register file; configuration is frozen while busy
    always_comb begin
        opa_n    = opa_r;
        opb_n    = opb_r;
        sgn_n    = sgn_r;
        op_n     = op_r;
        irq_en_n = irq_en_r;
        if (wr_en_s && !busy_s) begin
            case (addr_r)
                OFF_OPA:  opa_n = bus.hwdata[DATA_W-1:0];
                OFF_OPB:  opb_n = bus.hwdata[DATA_W-1:0];
                OFF_CTRL: begin
                    sgn_n    = bus.hwdata[CTRL_SIGNED];
                    op_n     = bus.hwdata[CTRL_OP];
                    irq_en_n = bus.hwdata[CTRL_IRQ_EN];
                end
                default: opa_n = opa_r;
            endcase
        end else begin
            opa_n = opa_r;
        end
        if (start_s) begin
            done_n = 1'b0;
            dbz_n  = 1'b0;
        end else if (wr_en_s && (addr_r == OFF_STATUS)) begin
            done_n = done_r & ~bus.hwdata[ST_DONE];
            dbz_n  = dbz_r & ~bus.hwdata[ST_DBZ];
        end else begin
            done_n = done_r;
            dbz_n  = dbz_r;
        end
        // A completion in the same cycle as a W1C write keeps the flag set
        done_n = done_n | done_p_s;
        dbz_n  = dbz_n | dbz_p_s;
        irq_n  = done_n & irq_en_n;
    end

    // Address-phase capture and register file state
    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            addr_r   <= 8'h00;
            sel_r    <= 1'b0;
            trans_r  <= 1'b0;
            write_r  <= 1'b0;
            opa_r    <= {DATA_W{1'b0}};
            opb_r    <= {DATA_W{1'b0}};
            sgn_r    <= 1'b0;
            op_r     <= 1'b0;
            irq_en_r <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            addr_r   <= bus.haddr[7:0];
            sel_r    <= bus.hsel;
            trans_r  <= bus.htrans[1];
            write_r  <= bus.hwrite;
            opa_r    <= opa_n;
            opb_r    <= opb_n;
            sgn_r    <= sgn_n;
            op_r     <= op_n;
            irq_en_r <= irq_en_n;
            done_r   <= done_n;
            dbz_r    <= dbz_n;
            irq_r    <= irq_n;
        end
    end

    // Read data mux for the current data phase
    always_comb begin
        rdata_s = RST_RDATA;
        if (rd_en_s) begin
            case (addr_r)
                OFF_OPA:    rdata_s = 32'(opa_r);
                OFF_OPB:    rdata_s = 32'(opb_r);
                OFF_CTRL:   rdata_s = {28'h000_0000, irq_en_r, op_r, sgn_r, 1'b0};
                OFF_STATUS: rdata_s = {29'h0000_0000, dbz_r, done_r, busy_s};
                OFF_RES_LO: rdata_s = res_lo_s;
                OFF_RES_HI: rdata_s = res_hi_s;
                default:    rdata_s = RST_RDATA;
            endcase
        end else begin
            rdata_s = RST_RDATA;
        end
    end

    assign bus.hrdata = rdata_s;
    assign bus.hready = 1'b1;
    assign bus.hresp  = 2'b00;
    assign IRQ        = irq_r;

endmodule
